// File: rtl/xadc_drp_arbiter_if.sv
// Signal bundle between the two DRP requesters, the arbiter and the XADC primitive.
// master = requester/primitive side, slave = arbiter.
interface xadc_drp_arbiter_if;
   logic        a_req, a_we, a_ack, a_err;
   logic [6:0]  a_addr;
   logic [15:0] a_di, a_rdata;
   logic        b_req, b_we, b_ack, b_err;
   logic [6:0]  b_addr;
   logic [15:0] b_di, b_rdata;
   logic        BUSY, DRDY, DEN, DWE;
   logic [15:0] DO, DI;
   logic [6:0]  DADDR;

   modport master (
      output a_req, a_we, a_addr, a_di, b_req, b_we, b_addr, b_di, BUSY, DO, DRDY,
      input  a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, DADDR, DEN, DI, DWE
   );
   modport slave (
      input  a_req, a_we, a_addr, a_di, b_req, b_we, b_addr, b_di, BUSY, DO, DRDY,
      output a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, DADDR, DEN, DI, DWE
   );
endinterface

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP between port A and port B,
// one DEN strobe per access, DRDY timeout recovery.
module xadc_drp_arbiter #(
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   xadc_drp_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_n;
   logic        owner, owner_n, last_owner, last_owner_n;  // 0 = A, 1 = B
   logic [15:0] timer, timer_n;
   logic        den_n, dwe_n;
   logic [6:0]  daddr_n;
   logic [15:0] di_n, a_rdata_n, b_rdata_n;
   logic        a_ack_n, a_err_n, b_ack_n, b_err_n;
   logic        a_elig, b_elig, grant_b;

   // Writes wait out BUSY; reads go through regardless.
   assign a_elig  = bus.a_req & (~bus.a_we | ~bus.BUSY);
   assign b_elig  = bus.b_req & (~bus.b_we | ~bus.BUSY);
   assign grant_b = b_elig & (~a_elig | ~last_owner);

   always_comb begin
      state_n      = state;
      owner_n      = owner;
      last_owner_n = last_owner;
      timer_n      = timer;
      den_n        = 1'b0;
      dwe_n        = 1'b0;
      daddr_n      = bus.DADDR;
      di_n         = bus.DI;
      a_ack_n      = 1'b0;
      a_err_n      = 1'b0;
      b_ack_n      = 1'b0;
      b_err_n      = 1'b0;
      a_rdata_n    = bus.a_rdata;
      b_rdata_n    = bus.b_rdata;
      case (state)
         IDLE: begin
            if (a_elig | b_elig) begin
               den_n        = 1'b1;
               dwe_n        = grant_b ? bus.b_we   : bus.a_we;
               daddr_n      = grant_b ? bus.b_addr : bus.a_addr;
               di_n         = grant_b ? bus.b_di   : bus.a_di;
               owner_n      = grant_b;
               last_owner_n = grant_b;
               timer_n      = 16'd0;
               state_n      = WAIT;
            end
         end
         WAIT: begin
            timer_n = timer + 16'd1;
            // DRDY takes priority over a coincident timeout.
            if (bus.DRDY) begin
               if (owner) begin
                  b_ack_n   = 1'b1;
                  b_rdata_n = bus.DO;
               end else begin
                  a_ack_n   = 1'b1;
                  a_rdata_n = bus.DO;
               end
               state_n = DONE;
            end else if (timer == TMO_LAST) begin
               if (owner) begin
                  b_ack_n = 1'b1;
                  b_err_n = 1'b1;
               end else begin
                  a_ack_n = 1'b1;
                  a_err_n = 1'b1;
               end
               state_n = DONE;
            end
         end
         DONE: begin
            // Dead cycle so a req dropped on ack is never re-granted.
            daddr_n = 7'd0;
            di_n    = 16'd0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         timer       <= 16'd0;
         bus.DEN     <= 1'b0;
         bus.DWE     <= 1'b0;
         bus.DADDR   <= 7'd0;
         bus.DI      <= 16'd0;
         bus.a_ack   <= 1'b0;
         bus.a_err   <= 1'b0;
         bus.a_rdata <= 16'd0;
         bus.b_ack   <= 1'b0;
         bus.b_err   <= 1'b0;
         bus.b_rdata <= 16'd0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         last_owner  <= last_owner_n;
         timer       <= timer_n;
         bus.DEN     <= den_n;
         bus.DWE     <= dwe_n;
         bus.DADDR   <= daddr_n;
         bus.DI      <= di_n;
         bus.a_ack   <= a_ack_n;
         bus.a_err   <= a_err_n;
         bus.a_rdata <= a_rdata_n;
         bus.b_ack   <= b_ack_n;
         bus.b_err   <= b_err_n;
         bus.b_rdata <= b_rdata_n;
      end
   end
endmodule

// File: doc/xadc_drp_arbiter.md
# xadc_drp_arbiter

Two-port arbiter that shares the single XADC dynamic reconfiguration port (DRP) between a sequential measurement reader (port A) and a configuration/host requester (port B). It serialises DRP transactions, issues a one-cycle DEN strobe per access, returns DO data to the owning requester and recovers from a missing DRDY with a timeout. It sits between the measurement/network-output logic and the XADC primitive.

## Interface
- TIMEOUT, 255: WAIT-state cycles without DRDY before the transaction is aborted; range 1..65535
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  port A request, level; held until a_ack
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  7  port A DRP address
- a_di  in  16  port A write data
- a_ack  out  1  port A completion pulse, 1 cycle
- a_err  out  1  port A timeout flag, valid with a_ack
- a_rdata  out  16  port A read data, valid with a_ack, held until next A completion
- b_req, b_we, b_addr, b_di, b_ack, b_err, b_rdata: identical to port A, for port B
- BUSY  in  1  XADC conversion/calibration busy
- DO  in  16  DRP read data
- DRDY  in  1  DRP data ready
- DADDR  out  7  DRP address
- DEN  out  1  DRP enable strobe
- DI  out  16  DRP write data
- DWE  out  1  DRP write enable

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE.
- Reset values: all outputs 0; last_owner = B (so A wins the first tie); timer = 0.
- IDLE: eligible port = req high and (we = 0 or BUSY = 0); writes are held off while BUSY, reads are not.
  - One eligible: granted. Both eligible: the port not equal to last_owner is granted (round-robin).
  - On grant (registered): DEN=1, DWE=we, DADDR=addr, DI=di of winner; owner and last_owner ← winner; timer ← 0; → WAIT.
  - No eligible port: DEN, DWE = 0; stay.
- WAIT: DEN=0, DWE=0 from the first WAIT cycle; DADDR/DI hold. timer increments per cycle.
  - DRDY=1: owner rdata ← DO (reads and writes alike), owner ack=1, err=0; → DONE.
  - DRDY=0 and timer = TIMEOUT-1: owner ack=1, err=1, rdata unchanged; → DONE.
  - If DRDY and timeout coincide, DRDY wins (err=0).
- DONE: ack/err deassert; DADDR, DI ← 0; requests ignored for this cycle; → IDLE.
- DRDY while in IDLE or DONE is ignored.
- Requesters must drop req on the edge where they see ack; the DONE cycle guarantees that a dropped req is never re-granted.
- The timer is 16 bits and never wraps within a transaction.
- Reset mid-transaction: immediate return to reset values; no ack is issued for the aborted access.

## Timing
- req high before edge E0 in IDLE → DEN high for exactly the cycle after E0.
- DRDY high in cycle k (k ≥ 1 after DEN) → ack, err and rdata valid in cycle k+1 (registered).
- Earliest re-grant is the edge after DONE. Minimum request-to-request throughput: DEN, ≥1 WAIT, DONE, IDLE = 4 cycles.
- A timeout asserts ack exactly TIMEOUT cycles after the DEN cycle ends.
- BUSY is sampled only in IDLE. BUSY rising during WAIT does not affect an in-flight write.

## Test plan
- Single read A: a_req=1, a_addr=7'h10; DRDY with DO=16'hABC0 two cycles after DEN → DEN 1 cycle, DADDR=7'h10, DWE=0, a_ack 1 cycle with a_rdata=16'hABC0, a_err=0; b_ack stays 0.
- Simultaneous requests: a_req and b_req both high from reset, each re-requests after ack → grants go A, B, A, B; DADDR alternates a_addr/b_addr; each ack is matched to the correct port.
- Write blocked by BUSY: b_we=1, b_addr=7'h41, b_di=16'h2000, BUSY=1 for 10 cycles, a read on A pending → A is served and no DEN with DWE=1 occurs; after BUSY=0, DEN=DWE=1, DI=16'h2000 on the next grant.
- Timeout: TIMEOUT=8, A read, DRDY never asserted → a_ack=1, a_err=1 8 cycles after the DEN cycle; a_rdata keeps its prior value; the next request is then granted normally.
- DRDY and timeout coincide: DRDY arrives on the final timer cycle with DO=16'h1230 → a_err=0, a_rdata=16'h1230.
- Reset mid-WAIT: rst pulsed while in WAIT → all outputs 0, no ack; a stray DRDY afterwards is ignored; the first tie after reset is granted to A.
